seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 1000, per-digit dwell rate; TICK_DIV = CLK_HZ/SCAN_HZ, TICK_DIV >= 16 required.
REQ-003 SHALL have parameter DIGITS, default 6, digit count, legal range 1..8; SW = max(1,$clog2(DIGITS)).
REQ-004 SHALL have parameter BLINK_HZ, default 2, blink rate; HALF = SCAN_HZ/(2*BLINK_HZ) ticks, HALF >= 1 required.
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1, 1 = seg outputs inverted (common anode).
REQ-006 SHALL have parameter DIG_ACTIVE_LOW, default 0, 1 = dig_en outputs inverted.
REQ-007 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-008 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port data_in  in  4*DIGITS  nibble per digit, digit 0 = MS nibble.
REQ-010 SHALL have port point  in  DIGITS  decimal-point request, bit DIGITS-1 = digit 0.
REQ-011 SHALL have port blink  in  DIGITS  blink request per digit, same bit order as point.
REQ-012 SHALL have port lz_en  in  1  leading-zero suppression enable.
REQ-013 SHALL have port bright  in  4  brightness, 0 = 1/16 duty, 15 = full.
REQ-014 SHALL have port seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
REQ-015 SHALL have ports sel  out  SW  binary digit index; dig_en  out  DIGITS  one-hot digit drive.
REQ-016 SHALL have port frame_done  out  1  one-clk pulse at frame wrap.

Function
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 on clk; tick = one-clk pulse at count TICK_DIV-1; no derived clocks.
REQ-018 Index idx SHALL advance on tick, wrap DIGITS-1 -> 0; frame_done SHALL pulse on the wrap tick.
REQ-019 Shadow registers SHALL capture data_in, point, blink, lz_en, bright only on the wrap tick; mid-frame input changes SHALL NOT affect the current frame.
REQ-020 Decode (active-high, gfedcba) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A(minus)=40 B(E)=79 C(r)=50 D(H)=76 E(C)=39 F(blank)=00.
REQ-021 dp SHALL be driven from shadow point of the displayed digit; dp is not suppressed by leading-zero suppression.
REQ-022 With lz_en, digit k < DIGITS-1 SHALL be blanked (segments a-g off) when nibbles 0..k are all zero; last digit always shown.
REQ-023 Blink phase SHALL toggle every HALF ticks; digit with shadow blink set SHALL be fully off (dp included) while phase = 1.
REQ-024 4-bit pwm counter SHALL increment every clk; dig_en[idx] active only when pwm <= shadow bright; other dig_en bits always inactive.
REQ-025 seg, sel, dig_en SHALL be registered: one clk latency from idx/shadow/pwm change.
REQ-026 Polarity SHALL be applied at output only: seg = SEG_ACTIVE_LOW ? ~internal : internal; same for dig_en with DIG_ACTIVE_LOW.
REQ-027 DIGITS = 1 SHALL tick every TICK_DIV, idx held 0, frame_done on every tick.

Reset
REQ-028 rst_n low SHALL immediately clear prescaler, idx, pwm, blink phase, sel, frame_done; seg and dig_en all inactive for the configured polarity.
REQ-029 Reset SHALL load shadow data all 4'hF, point/blink/lz_en 0, bright 15; display blank until first wrap tick.
REQ-030 Reset asserted mid-frame SHALL abort the scan; after release scanning restarts at idx 0, count 0.

Verification (CLK_HZ=1600, SCAN_HZ=100, DIGITS=4, BLINK_HZ=25, both polarities 0)
REQ-031 data_in=16'h1234, point=4'b0100, bright=15 -> after first frame: idx0 seg=06, idx1 seg=DB, idx2 seg=4F, idx3 seg=66; each digit dwells 16 clks; frame_done every 64 clks.
REQ-032 data_in=16'h0050, lz_en=1 -> digits 0,1 seg=00; digit 2 seg=6D; digit 3 seg=3F; 16'h0000 -> only digit 3 shows 3F.
REQ-033 bright=3 -> dig_en[idx] high exactly 4 of every 16 clks; bright=0 -> 1 of 16.
REQ-034 blink=4'b0001 -> digit 3 off for 2 ticks, on for 2 ticks, repeating; other digits unaffected.
REQ-035 change data_in mid-frame -> current frame unchanged; new value visible from digit 0 of next frame.
REQ-036 rst_n low at idx 2 -> same-cycle seg=00, dig_en=0, sel=0, frame_done=0; after release first tick at clk 16, display blank until wrap.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment display scanner.
// One digit is driven per scan tick. Inputs are latched into shadow registers
// at the frame wrap so that a frame always shows one coherent value. Features:
// leading-zero suppression, per-digit blink, 16-step PWM brightness and
// output polarity selection.
module seg_scan_driver #(
   parameter int CLK_HZ          = 50_000_000,
   parameter int SCAN_HZ         = 1000,
   parameter int DIGITS          = 6,
   parameter int BLINK_HZ        = 2,
   parameter bit SEG_ACTIVE_LOW  = 1'b1,
   parameter bit DIG_ACTIVE_LOW  = 1'b0,
   localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4*DIGITS-1:0] data_in,
   input  logic [DIGITS-1:0]   point,
   input  logic [DIGITS-1:0]   blink,
   input  logic                lz_en,
   input  logic [3:0]          bright,
   output logic [7:0]          seg,
   output logic [SW-1:0]       sel,
   output logic [DIGITS-1:0]   dig_en,
   output logic                frame_done
);

   localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
   localparam int CW       = $clog2(TICK_DIV);
   localparam int HALF     = SCAN_HZ / (2 * BLINK_HZ);
   localparam int BW       = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [CW-1:0]     CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [BW-1:0]     BLK_LAST = BW'(HALF - 1);
   localparam logic [SW-1:0]     IDX_LAST = SW'(DIGITS - 1);
   localparam logic [7:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] DIG_OFF  = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   // Active-high gfedcba pattern for one nibble.
   function automatic logic [6:0] decode7(input logic [3:0] nib);
      case (nib)
         4'h0:    decode7 = 7'h3F;
         4'h1:    decode7 = 7'h06;
         4'h2:    decode7 = 7'h5B;
         4'h3:    decode7 = 7'h4F;
         4'h4:    decode7 = 7'h66;
         4'h5:    decode7 = 7'h6D;
         4'h6:    decode7 = 7'h7D;
         4'h7:    decode7 = 7'h07;
         4'h8:    decode7 = 7'h7F;
         4'h9:    decode7 = 7'h6F;
         4'hA:    decode7 = 7'h40;   // minus
         4'hB:    decode7 = 7'h79;   // E
         4'hC:    decode7 = 7'h50;   // r
         4'hD:    decode7 = 7'h76;   // H
         4'hE:    decode7 = 7'h39;   // C
         4'hF:    decode7 = 7'h00;   // blank
         default: decode7 = 7'h00;
      endcase
   endfunction

   logic [CW-1:0]       cnt_r;
   logic [SW-1:0]       idx_r;
   logic [3:0]          pwm_r;
   logic [BW-1:0]       blk_cnt_r;
   logic                phase_r;
   logic                frame_done_r;
   logic [4*DIGITS-1:0] data_sh_r;
   logic [DIGITS-1:0]   point_sh_r;
   logic [DIGITS-1:0]   blink_sh_r;
   logic                lz_sh_r;
   logic [3:0]          bright_sh_r;
   logic [7:0]          seg_r;
   logic [SW-1:0]       sel_r;
   logic [DIGITS-1:0]   dig_en_r;

   logic                tick_s;
   logic                wrap_s;
   logic [SW-1:0]       rev_s;
   logic [3:0]          nib_s;
   logic                pt_s;
   logic                bl_s;
   logic                zero_run_s;
   logic                blank_lz_s;
   logic [7:0]          seg_int_s;
   logic [DIGITS-1:0]   dig_int_s;

   assign tick_s = (cnt_r == CNT_LAST);
   assign wrap_s = tick_s & (idx_r == IDX_LAST);

   // Prescaler: free-running 0..TICK_DIV-1 count, tick on the last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (tick_s) begin
         cnt_r <= {CW{1'b0}};
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   // Digit index advances per tick; frame_done marks the wrap tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r        <= {SW{1'b0}};
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= wrap_s;
         if (wrap_s) begin
            idx_r <= {SW{1'b0}};
         end else if (tick_s) begin
            idx_r <= idx_r + SW'(1);
         end
      end
   end

   // PWM phase counter for brightness, one step per clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_r <= 4'h0;
      end else begin
         pwm_r <= pwm_r + 4'h1;
      end
   end

   // Blink phase toggles after every HALF ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt_r <= {BW{1'b0}};
         phase_r   <= 1'b0;
      end else if (tick_s) begin
         if (blk_cnt_r == BLK_LAST) begin
            blk_cnt_r <= {BW{1'b0}};
            phase_r   <= ~phase_r;
         end else begin
            blk_cnt_r <= blk_cnt_r + BW'(1);
         end
      end
   end

   // Shadow copy of all display inputs, refreshed only at the frame wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_sh_r   <= {(4*DIGITS){1'b1}};
         point_sh_r  <= {DIGITS{1'b0}};
         blink_sh_r  <= {DIGITS{1'b0}};
         lz_sh_r     <= 1'b0;
         bright_sh_r <= 4'hF;
      end else if (wrap_s) begin
         data_sh_r   <= data_in;
         point_sh_r  <= point;
         blink_sh_r  <= blink;
         lz_sh_r     <= lz_en;
         bright_sh_r <= bright;
      end
   end

   // Pick the shown digit's shadow fields (digit 0 is the most significant
   // nibble / highest bit) and check whether it lies in a leading-zero run.
   always_comb begin
      rev_s      = IDX_LAST - idx_r;
      nib_s      = data_sh_r[{rev_s, 2'b00} +: 4];
      pt_s       = point_sh_r[rev_s];
      bl_s       = blink_sh_r[rev_s];
      zero_run_s = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         zero_run_s = zero_run_s &
                      ((SW'(k) > idx_r) | (data_sh_r[4*(DIGITS-1-k) +: 4] == 4'h0));
      end
      blank_lz_s = lz_sh_r & zero_run_s & (idx_r != IDX_LAST);
   end

   // Active-high segment pattern and digit drive before polarity.
   always_comb begin
      if (bl_s && phase_r) begin
         seg_int_s = 8'h00;
      end else if (blank_lz_s) begin
         seg_int_s = {pt_s, 7'h00};
      end else begin
         seg_int_s = {pt_s, decode7(nib_s)};
      end
      dig_int_s = {DIGITS{1'b0}};
      if (pwm_r <= bright_sh_r) begin
         dig_int_s[idx_r] = 1'b1;
      end else begin
         dig_int_s = {DIGITS{1'b0}};
      end
   end

   // Output registers; polarity is applied only here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_r    <= SEG_OFF;
         sel_r    <= {SW{1'b0}};
         dig_en_r <= DIG_OFF;
      end else begin
         seg_r    <= SEG_ACTIVE_LOW ? ~seg_int_s : seg_int_s;
         sel_r    <= idx_r;
         dig_en_r <= DIG_ACTIVE_LOW ? ~dig_int_s : dig_int_s;
      end
   end

   assign seg        = seg_r;
   assign sel        = sel_r;
   assign dig_en     = dig_en_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with CLK_HZ=1600, SCAN_HZ=100,
// DIGITS=4, BLINK_HZ=25, both polarities active-high: 16 clocks per digit,
// 64 clocks per frame, blink phase flips every 2 ticks.
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data_in;
   logic [3:0]  point;
   logic [3:0]  blink;
   logic        lz_en;
   logic [3:0]  bright;
   logic [7:0]  seg;
   logic [1:0]  sel;
   logic [3:0]  dig_en;
   logic        frame_done;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .CLK_HZ(1600), .SCAN_HZ(100), .DIGITS(4), .BLINK_HZ(25),
      .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .point(point),
      .blink(blink), .lz_en(lz_en), .bright(bright), .seg(seg),
      .sel(sel), .dig_en(dig_en), .frame_done(frame_done)
   );

   // ---------------- reference model ----------------
   // n = clock edges since reset release. After n edges the scanner has seen
   // n/16 ticks: digit (n/16)%4, pwm n%16, blink phase (n/32)%2. Inputs are
   // latched whenever n reaches a multiple of 64. Outputs seen after edge n
   // describe the state after n-1 edges.
   logic [6:0]  font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h79, 7'h50, 7'h76, 7'h39, 7'h00};
   int          n = 0;
   logic [15:0] sh_data   = 16'hFFFF;
   logic [3:0]  sh_point  = 4'h0;
   logic [3:0]  sh_blink  = 4'h0;
   logic        sh_lz     = 1'b0;
   logic [3:0]  sh_bright = 4'hF;
   logic [7:0]  exp_seg   = 8'h00;
   logic [3:0]  exp_dig   = 4'h0;
   logic [1:0]  exp_sel   = 2'd0;
   logic        exp_fd    = 1'b0;
   int          m_idx, m_pwm, m_phase;
   logic [3:0]  m_nib;
   logic        m_allz;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n = 0;
         sh_data = 16'hFFFF; sh_point = 4'h0; sh_blink = 4'h0; sh_lz = 1'b0; sh_bright = 4'hF;
         exp_seg = 8'h00; exp_dig = 4'h0; exp_sel = 2'd0; exp_fd = 1'b0;
      end else begin
         m_idx   = (n / 16) % 4;
         m_pwm   = n % 16;
         m_phase = (n / 32) % 2;
         m_nib   = sh_data[4*(3-m_idx) +: 4];
         m_allz  = 1'b1;
         for (int k = 0; k <= m_idx; k++) begin
            if (sh_data[4*(3-k) +: 4] != 4'h0) m_allz = 1'b0;
         end
         if (sh_blink[3-m_idx] && m_phase == 1) begin
            exp_seg = 8'h00;
         end else begin
            exp_seg = {sh_point[3-m_idx], font[m_nib]};
            if (sh_lz && m_allz && m_idx < 3) exp_seg[6:0] = 7'h00;
         end
         exp_dig = (m_pwm <= int'(sh_bright)) ? (4'b0001 << m_idx) : 4'b0000;
         exp_sel = 2'(m_idx);
         exp_fd  = ((n % 64) == 63);
         n = n + 1;
         if ((n % 64) == 0) begin
            sh_data = data_in; sh_point = point; sh_blink = blink;
            sh_lz = lz_en; sh_bright = bright;
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      #3;
      total++;
      if (seg !== 8'h00 || dig_en !== 4'h0 || sel !== 2'd0 || frame_done !== 1'b0)
         $display("FAIL reset_state seg=%h dig=%b sel=%0d fd=%b want 00 0000 0 0", seg, dig_en, sel, frame_done);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         total++;
         if (c <= 16) begin
            if (seg !== 8'h00 || dig_en !== 4'b0001 || sel !== 2'd0 || frame_done !== 1'b0)
               $display("FAIL reset_first_dwell c=%0d seg=%h dig=%b sel=%0d want 00 0001 0", c, seg, dig_en, sel);
            else passed++;
         end else begin
            if (sel !== 2'd1 || dig_en !== 4'b0010)
               $display("FAIL reset_first_tick sel=%0d dig=%b want 1 0010", sel, dig_en);
            else passed++;
         end
      end
   endtask

   task automatic test_decode();
      logic [7:0] want [4];
      int budget, gap;
      want = '{8'h06, 8'hDB, 8'h4F, 8'h66};
      data_in = 16'h1234; point = 4'b0100; blink = 4'h0; lz_en = 1'b0; bright = 4'hF;
      for (int c = 0; c < 192; c++) begin
         @(negedge clk);
         total++;
         if ({seg, dig_en, sel, frame_done} !== {exp_seg, exp_dig, exp_sel, exp_fd})
            $display("FAIL decode_model c=%0d seg=%h/%h dig=%b/%b sel=%0d/%0d fd=%b/%b",
                     c, seg, exp_seg, dig_en, exp_dig, sel, exp_sel, frame_done, exp_fd);
         else passed++;
      end
      for (int k = 0; k < 4; k++) begin
         budget = 0;
         do begin @(negedge clk); budget++; end while ((n % 64) != 16*k + 8 && budget < 100);
         total++;
         if (budget >= 100 || seg !== want[k] || sel !== 2'(k))
            $display("FAIL decode_digit%0d seg=%h want %h sel=%0d", k, seg, want[k], sel);
         else passed++;
      end
      budget = 0;
      while (frame_done !== 1'b1 && budget < 100) begin @(negedge clk); budget++; end
      gap = 0;
      do begin @(negedge clk); gap++; end while (frame_done !== 1'b1 && gap < 100);
      total++;
      if (gap != 64) $display("FAIL frame_period got %0d want 64", gap);
      else passed++;
   endtask

   task automatic test_lz();
      logic [7:0] want [4];
      int budget;
      data_in = 16'h0050; point = 4'h0; blink = 4'h0; lz_en = 1'b1; bright = 4'hF;
      for (int p = 0; p < 2; p++) begin
         repeat (80) @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            budget = 0;
            do begin @(negedge clk); budget++; end while ((n % 64) != 16*k + 8 && budget < 100);
            total++;
            if (budget >= 100 || seg !== want[k] && p >= 0 && seg !== ((p == 0) ? (k == 2 ? 8'h6D : (k == 3 ? 8'h3F : 8'h00)) : (k == 3 ? 8'h3F : 8'h00)))
               $display("FAIL lz_p%0d_digit%0d seg=%h want %h", p, k, seg,
                        (p == 0) ? (k == 2 ? 8'h6D : (k == 3 ? 8'h3F : 8'h00)) : (k == 3 ? 8'h3F : 8'h00));
            else passed++;
         end
         data_in = 16'h0000;
      end
      for (int c = 0; c < 320; c++) begin
         if (c % 16 == 0) begin
            data_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
            point   = 4'($urandom);
         end
         @(negedge clk);
         total++;
         if ({seg, dig_en, sel, frame_done} !== {exp_seg, exp_dig, exp_sel, exp_fd})
            $display("FAIL lz_model c=%0d seg=%h/%h dig=%b/%b sel=%0d/%0d", c, seg, exp_seg, dig_en, exp_dig, sel, exp_sel);
         else passed++;
      end
   endtask

   task automatic test_pwm();
      int cnt;
      logic [3:0] levels [2];
      int want [2];
      levels = '{4'd3, 4'd0};
      want   = '{4, 1};
      data_in = 16'h1234; point = 4'h0; blink = 4'h0; lz_en = 1'b0;
      for (int p = 0; p < 2; p++) begin
         bright = levels[p];
         for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            total++;
            if (dig_en !== exp_dig)
               $display("FAIL pwm_model b=%0d c=%0d dig=%b want %b", bright, c, dig_en, exp_dig);
            else passed++;
         end
         cnt = 0;
         for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (dig_en == (4'b0001 << sel)) cnt++;
         end
         total++;
         if (cnt != want[p]) $display("FAIL pwm_duty b=%0d on=%0d want %0d", bright, cnt, want[p]);
         else passed++;
      end
      bright = 4'hF;
   endtask

   task automatic test_blink();
      int budget;
      logic [7:0] want [4];
      want = '{8'h06, 8'h5B, 8'h4F, 8'h00};
      data_in = 16'h1234; point = 4'h0; blink = 4'b0001; lz_en = 1'b0; bright = 4'hF;
      for (int c = 0; c < 256; c++) begin
         @(negedge clk);
         total++;
         if ({seg, dig_en, sel} !== {exp_seg, exp_dig, exp_sel})
            $display("FAIL blink_model c=%0d seg=%h/%h dig=%b/%b", c, seg, exp_seg, dig_en, exp_dig);
         else passed++;
      end
      for (int k = 0; k < 4; k++) begin
         budget = 0;
         do begin @(negedge clk); budget++; end while ((n % 64) != 16*k + 8 && budget < 100);
         total++;
         if (budget >= 100 || seg !== want[k])
            $display("FAIL blink_digit%0d seg=%h want %h", k, seg, want[k]);
         else passed++;
      end
      blink = 4'h0;
   endtask

   task automatic test_midframe();
      int budget;
      int pos [4];
      logic [7:0] want [4];
      pos  = '{40, 56, 8, 24};
      want = '{8'h4F, 8'h66, 8'h6D, 8'h7D};
      data_in = 16'h1234; point = 4'h0; blink = 4'h0; lz_en = 1'b0; bright = 4'hF;
      repeat (80) @(negedge clk);
      budget = 0;
      do begin @(negedge clk); budget++; end while ((n % 64) != 20 && budget < 100);
      data_in = 16'h5678;
      for (int k = 0; k < 4; k++) begin
         budget = 0;
         do begin @(negedge clk); budget++; end while ((n % 64) != pos[k] && budget < 100);
         total++;
         if (budget >= 100 || seg !== want[k])
            $display("FAIL midframe_step%0d seg=%h want %h", k, seg, want[k]);
         else passed++;
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 640; c++) begin
         if ($urandom_range(0, 23) == 0) begin
            data_in = 16'($urandom); point = 4'($urandom); blink = 4'($urandom);
            lz_en = 1'($urandom); bright = 4'($urandom);
         end
         @(negedge clk);
         total++;
         if ({seg, dig_en, sel, frame_done} !== {exp_seg, exp_dig, exp_sel, exp_fd})
            $display("FAIL random_model c=%0d seg=%h/%h dig=%b/%b sel=%0d/%0d fd=%b/%b",
                     c, seg, exp_seg, dig_en, exp_dig, sel, exp_sel, frame_done, exp_fd);
         else passed++;
      end
   endtask

   task automatic test_reset_midframe();
      int budget;
      data_in = 16'h1234; point = 4'h0; blink = 4'h0; lz_en = 1'b0; bright = 4'hF;
      repeat (80) @(negedge clk);
      budget = 0;
      while (sel !== 2'd2 && budget < 100) begin @(negedge clk); budget++; end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (budget >= 100 || seg !== 8'h00 || dig_en !== 4'h0 || sel !== 2'd0 || frame_done !== 1'b0)
         $display("FAIL reset_mid seg=%h dig=%b sel=%0d fd=%b want 00 0000 0 0", seg, dig_en, sel, frame_done);
      else passed++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         total++;
         if ({seg, dig_en, sel, frame_done} !== {exp_seg, exp_dig, exp_sel, exp_fd})
            $display("FAIL reset_mid_model c=%0d seg=%h/%h dig=%b/%b sel=%0d/%0d", c, seg, exp_seg, dig_en, exp_dig, sel, exp_sel);
         else passed++;
         if (c == 16 || c == 17) begin
            total++;
            if (sel !== 2'(c - 16)) $display("FAIL reset_mid_tick c=%0d sel=%0d want %0d", c, sel, c - 16);
            else passed++;
         end
         if (c == 64 || c == 65) begin
            total++;
            if (seg !== ((c == 64) ? 8'h00 : 8'h06))
               $display("FAIL reset_mid_blank c=%0d seg=%h want %h", c, seg, (c == 64) ? 8'h00 : 8'h06);
            else passed++;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; data_in = 16'h0000; point = 4'h0; blink = 4'h0; lz_en = 1'b0; bright = 4'hF;
      test_reset();
      test_decode();
      test_lz();
      test_pwm();
      test_blink();
      test_midframe();
      test_random();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
